// File: rtl/bn_ctrl_pkg.sv
// Shared types and constants for the batch-norm engine sharing logic.
package bn_ctrl_pkg;

    // Default channels per vector.
    localparam int N_LANES = 16;

    // One Q4.12 channel value and a full vector of them.
    typedef logic signed [15:0] q4_12_t;
    typedef q4_12_t [N_LANES-1:0] q4_12_vec_t;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bn_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_arbiter #(
    parameter int N_REQ = 3,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scan offsets from farthest to nearest so the nearest match to ptr wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bn_share_arbiter.sv
// Time-shares one batch-norm engine among N_REQ layer requesters with
// round-robin grants, a bounded wait for the engine result, and a
// held response until the owning requester accepts it.
module bn_share_arbiter #(
    parameter int N_REQ       = 3,
    parameter int N_LANES     = 16,
    parameter int TIMEOUT_CYC = 8,
    localparam int SEL_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req_valid_in,
    input  logic [N_REQ-1:0][N_LANES-1:0][15:0]  req_data_in,
    output logic [N_REQ-1:0]                     req_ready_out,
    output logic [N_LANES-1:0][15:0]             eng_data_out,
    output logic                                 eng_valid_out,
    output logic [SEL_W-1:0]                     eng_layer_sel_out,
    input  logic                                 eng_valid_in,
    input  logic [N_LANES-1:0][15:0]             eng_data_in,
    output logic [N_REQ-1:0]                     rsp_valid_out,
    output logic [N_LANES-1:0][15:0]             rsp_data_out,
    input  logic [N_REQ-1:0]                     rsp_ready_in,
    output logic                                 busy_out,
    output logic                                 err_timeout_out,
    output logic [15:0]                          xfer_count_out
);

    import bn_ctrl_pkg::*;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    bn_state_t          state_reg;
    logic [SEL_W-1:0]   rr_ptr_reg;
    logic [SEL_W-1:0]   g_reg;
    logic [CW-1:0]      cnt_reg;
    logic [N_REQ-1:0]   g_onehot;

    logic [N_REQ-1:0]   arb_grant;
    logic [SEL_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req   (req_valid_in),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // One-hot decode of the stored grant, used to address the response.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner
            assign g_onehot[gi] = (g_reg == SEL_W'(gi));
        end
    endgenerate

    // Accept strobe only while arbitrating; everything else is registered.
    assign req_ready_out     = (state_reg == ST_IDLE) ? arb_grant : '0;
    assign busy_out          = (state_reg != ST_IDLE);
    assign eng_layer_sel_out = g_reg;

    // Sequencer: grant, issue, wait for result (bounded), hold response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= '0;
            g_reg           <= '0;
            cnt_reg         <= '0;
            eng_data_out    <= '0;
            eng_valid_out   <= 1'b0;
            rsp_valid_out   <= '0;
            rsp_data_out    <= '0;
            err_timeout_out <= 1'b0;
            xfer_count_out  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        eng_data_out  <= req_data_in[arb_idx];
                        g_reg         <= arb_idx;
                        rr_ptr_reg    <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
                        eng_valid_out <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    eng_valid_out <= 1'b0;
                    cnt_reg       <= '0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_valid_in) begin
                        rsp_data_out  <= eng_data_in;
                        rsp_valid_out <= g_onehot;
                        state_reg     <= ST_RESP;
                    end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
                        // Engine never answered: drop the vector and flag it.
                        cnt_reg         <= cnt_reg + 1'b1;
                        err_timeout_out <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (|(rsp_ready_in & g_onehot)) begin
                        rsp_valid_out  <= '0;
                        xfer_count_out <= xfer_count_out + 16'd1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bn_share_arbiter.sv
// Directed-vector bench for bn_share_arbiter.
module tb_bn_share_arbiter;

    localparam int N_REQ   = 3;
    localparam int N_LANES = 16;
    localparam int SEL_W   = 2;

    logic                                 clk;
    logic                                 reset;
    logic [N_REQ-1:0]                     req_valid_in;
    logic [N_REQ-1:0][N_LANES-1:0][15:0]  req_data_in;
    logic [N_REQ-1:0]                     req_ready_out;
    logic [N_LANES-1:0][15:0]             eng_data_out;
    logic                                 eng_valid_out;
    logic [SEL_W-1:0]                     eng_layer_sel_out;
    logic                                 eng_valid_in;
    logic [N_LANES-1:0][15:0]             eng_data_in;
    logic [N_REQ-1:0]                     rsp_valid_out;
    logic [N_LANES-1:0][15:0]             rsp_data_out;
    logic [N_REQ-1:0]                     rsp_ready_in;
    logic                                 busy_out;
    logic                                 err_timeout_out;
    logic [15:0]                          xfer_count_out;

    int n_tests = 0;
    int n_fail  = 0;

    bn_share_arbiter #(
        .N_REQ       (N_REQ),
        .N_LANES     (N_LANES),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid_in      (req_valid_in),
        .req_data_in       (req_data_in),
        .req_ready_out     (req_ready_out),
        .eng_data_out      (eng_data_out),
        .eng_valid_out     (eng_valid_out),
        .eng_layer_sel_out (eng_layer_sel_out),
        .eng_valid_in      (eng_valid_in),
        .eng_data_in       (eng_data_in),
        .rsp_valid_out     (rsp_valid_out),
        .rsp_data_out      (rsp_data_out),
        .rsp_ready_in      (rsp_ready_in),
        .busy_out          (busy_out),
        .err_timeout_out   (err_timeout_out),
        .xfer_count_out    (xfer_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_g;
        reset        = 1'b0;
        req_valid_in = '0;
        req_data_in  = '0;
        eng_valid_in = 1'b0;
        eng_data_in  = '0;
        rsp_ready_in = '0;
        for (int r = 0; r < N_REQ; r++) req_data_in[r][0] = 16'(100 + r);
        do_reset();

        // Reset state
        check("rst_busy",  32'(busy_out), 0);
        check("rst_ev",    32'(eng_valid_out), 0);
        check("rst_err",   32'(err_timeout_out), 0);
        check("rst_xfer",  32'(xfer_count_out), 0);
        check("rst_rspv",  32'(rsp_valid_out), 0);
        check("rst_rdy",   32'(req_ready_out), 0);
        check("rst_edata", 32'(eng_data_out[0]), 0);

        // Single request from requester 0
        req_data_in[0][0] = 16'sd4096;
        req_valid_in = 3'b001;
        #1;
        check("t1_ready", 32'(req_ready_out), 32'b001);
        tick();
        check("t1_ev",    32'(eng_valid_out), 1);
        check("t1_sel",   32'(eng_layer_sel_out), 0);
        check("t1_edata", 32'(eng_data_out[0]), 32'd4096);
        check("t1_rdy_issue", 32'(req_ready_out), 0);
        req_valid_in = 3'b000;
        eng_valid_in = 1'b1;
        eng_data_in[0] = 16'sd777;
        tick();
        check("t1_ev_off",   32'(eng_valid_out), 0);
        check("t1_no_early", 32'(rsp_valid_out), 0);
        tick();
        check("t1_rspv", 32'(rsp_valid_out), 32'b001);
        check("t1_rspd", 32'(rsp_data_out[0]), 32'd777);
        eng_valid_in = 1'b0;
        rsp_ready_in = 3'b001;
        tick();
        check("t1_xfer",   32'(xfer_count_out), 1);
        check("t1_rspv_0", 32'(rsp_valid_out), 0);
        check("t1_idle",   32'(busy_out), 0);
        rsp_ready_in = 3'b000;

        // Round-robin with all valid, engine valid stuck high, ready tied high
        req_data_in[0][0] = 16'd100;
        eng_valid_in = 1'b1;
        do_reset();
        req_valid_in = 3'b111;
        rsp_ready_in = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_g = i % 3;
            eng_data_in[0]  = 16'(200 + exp_g);
            eng_data_in[15] = 16'h8000 | 16'(exp_g);
            #1;
            check($sformatf("rr%0d_ready", i), 32'(req_ready_out), 32'(1 << exp_g));
            tick();
            check($sformatf("rr%0d_sel", i), 32'(eng_layer_sel_out), 32'(exp_g));
            check($sformatf("rr%0d_ed", i), 32'(eng_data_out[0]), 32'(100 + exp_g));
            tick();
            check($sformatf("rr%0d_wait_rspv", i), 32'(rsp_valid_out), 0);
            tick();
            check($sformatf("rr%0d_rspv", i), 32'(rsp_valid_out), 32'(1 << exp_g));
            check($sformatf("rr%0d_rd0", i), 32'(rsp_data_out[0]), 32'(200 + exp_g));
            check($sformatf("rr%0d_rd15", i), 32'(rsp_data_out[15]), 32'(16'h8000 | 16'(exp_g)));
            tick();
            check($sformatf("rr%0d_idle", i), 32'(busy_out), 0);
        end
        check("rr_xfer", 32'(xfer_count_out), 6);

        // Engine silent: timeout after 8 WAIT cycles
        req_valid_in = 3'b100;
        rsp_ready_in = 3'b000;
        eng_valid_in = 1'b0;
        #1;
        check("to_ready", 32'(req_ready_out), 32'b100);
        tick();
        req_valid_in = 3'b000;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("to_wait%0d_err", k), 32'(err_timeout_out), 0);
            check($sformatf("to_wait%0d_busy", k), 32'(busy_out), 1);
        end
        tick();
        check("to_err",  32'(err_timeout_out), 1);
        check("to_idle", 32'(busy_out), 0);
        check("to_rspv", 32'(rsp_valid_out), 0);
        check("to_xfer", 32'(xfer_count_out), 6);
        req_valid_in = 3'b010;
        #1;
        check("to2_ready", 32'(req_ready_out), 32'b010);
        tick();
        check("to2_sel", 32'(eng_layer_sel_out), 1);
        req_valid_in = 3'b000;
        tick();
        eng_valid_in   = 1'b1;
        eng_data_in[0] = 16'h0ABC;
        tick();
        check("to2_rspv", 32'(rsp_valid_out), 32'b010);
        check("to2_rspd", 32'(rsp_data_out[0]), 32'h0ABC);
        eng_valid_in = 1'b0;
        rsp_ready_in = 3'b010;
        tick();
        check("to2_xfer", 32'(xfer_count_out), 7);
        check("to2_err",  32'(err_timeout_out), 1);
        rsp_ready_in = 3'b000;

        // Response held while owner withholds ready
        req_valid_in = 3'b010;
        #1;
        check("hold_ready", 32'(req_ready_out), 32'b010);
        tick();
        tick();
        eng_valid_in   = 1'b1;
        eng_data_in[0] = 16'h1234;
        tick();
        req_valid_in = 3'b111;
        rsp_ready_in = 3'b101;
        for (int c = 0; c < 10; c++) begin
            eng_valid_in   = c[0];
            eng_data_in[0] = 16'(c * 3 + 5);
            tick();
            check($sformatf("hold%0d_rspv", c), 32'(rsp_valid_out), 32'b010);
            check($sformatf("hold%0d_rspd", c), 32'(rsp_data_out[0]), 32'h1234);
            check($sformatf("hold%0d_rdy", c), 32'(req_ready_out), 0);
            check($sformatf("hold%0d_ev", c), 32'(eng_valid_out), 0);
        end
        rsp_ready_in = 3'b010;
        req_valid_in = 3'b000;
        eng_valid_in = 1'b0;
        tick();
        check("hold_xfer", 32'(xfer_count_out), 8);
        check("hold_rspv", 32'(rsp_valid_out), 0);
        rsp_ready_in = 3'b000;

        // Reset during WAIT, then a late engine result
        req_valid_in = 3'b100;
        tick();
        req_valid_in = 3'b000;
        tick();
        check("rw_busy", 32'(busy_out), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        eng_valid_in   = 1'b1;
        eng_data_in[0] = 16'h7777;
        tick();
        check("rw_busy0",  32'(busy_out), 0);
        check("rw_rspv",   32'(rsp_valid_out), 0);
        check("rw_rspd",   32'(rsp_data_out[0]), 0);
        check("rw_err",    32'(err_timeout_out), 0);
        check("rw_xfer",   32'(xfer_count_out), 0);
        check("rw_ev",     32'(eng_valid_out), 0);
        check("rw_sel",    32'(eng_layer_sel_out), 0);
        check("rw_edata",  32'(eng_data_out[0]), 0);
        eng_valid_in = 1'b0;
        req_valid_in = 3'b111;
        #1;
        check("rw_ready", 32'(req_ready_out), 32'b001);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bn_share_arbiter.md
BN_SHARE_ARBITER -- requirements
Module: bn_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of layer requesters sharing one batch-norm engine.
REQ-002 Parameter N_LANES, default 16, channels per vector.
REQ-003 Parameter TIMEOUT_CYC, default 8, maximum cycles to wait for an engine result.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid_in  input  N_REQ  per-requester vector-available flag.
REQ-008 req_data_in  input  N_REQ x N_LANES x 16  signed Q4.12 vectors, one per requester.
REQ-009 req_ready_out  output  N_REQ  one-hot accept strobe to the granted requester.
REQ-010 eng_data_out  output  N_LANES x 16  registered Q4.12 vector driven to the engine.
REQ-011 eng_valid_out  output  1  single-cycle engine start pulse.
REQ-012 eng_layer_sel_out  output  clog2(N_REQ)  parameter-bank select for the engine (requester index).
REQ-013 eng_valid_in  input  1  engine result flag; may stay high indefinitely.
REQ-014 eng_data_in  input  N_LANES x 16  engine result vector, Q4.12.
REQ-015 rsp_valid_out  output  N_REQ  one-hot result-available flag to the owning requester.
REQ-016 rsp_data_out  output  N_LANES x 16  shared result bus, Q4.12.
REQ-017 rsp_ready_in  input  N_REQ  per-requester result acceptance.
REQ-018 busy_out  output  1  high when the state is not IDLE.
REQ-019 err_timeout_out  output  1  sticky engine-timeout flag.
REQ-020 xfer_count_out  output  16  count of completed responses; wraps from 65535 to 0.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: if any req_valid_in is set, pick grant g as the first set bit at or after rr_ptr (cyclic); req_ready_out[g]=1 combinationally in the same cycle; latch req_data_in[g] into eng_data_out; store g; rr_ptr <= (g+1) mod N_REQ; go to ISSUE.
REQ-023 IDLE with no req_valid_in: req_ready_out=0 and the state holds.
REQ-024 ISSUE: eng_valid_out=1 and eng_layer_sel_out=g for exactly one cycle; timeout counter cleared; go to WAIT.
REQ-025 WAIT: eng_valid_in is sampled only in this state; it is ignored in every other state.
REQ-026 WAIT with eng_valid_in=1: capture eng_data_in into rsp_data_out; go to RESP.
REQ-027 WAIT with eng_valid_in=0: increment the counter; when it reaches TIMEOUT_CYC, set err_timeout_out, drop the vector (no response), and go to IDLE.
REQ-028 RESP: rsp_valid_out[g]=1 and rsp_data_out is held stable.
REQ-029 RESP with rsp_ready_in[g]=1: increment xfer_count_out and go to IDLE the same edge.
REQ-030 RESP ignores rsp_ready_in bits other than g.
REQ-031 Minimum latency: 4 cycles per vector (IDLE, ISSUE, WAIT, RESP). Back-to-back grants are permitted from the IDLE cycle directly after a RESP handshake.
REQ-032 A requester may drop req_valid_in before grant without penalty; a granted vector is never re-requested.
REQ-033 Data is passed bit-exact; no arithmetic is applied. eng_layer_sel_out holds g from ISSUE through RESP.
REQ-034 Simultaneous requests are resolved by round-robin only.
REQ-035 Arbitration is starvation-free: a continuously valid requester is granted within N_REQ grants.

Reset
REQ-036 On reset: state=IDLE, rr_ptr=0, g=0, counter=0.
REQ-037 On reset, all outputs are 0, including err_timeout_out and xfer_count_out.
REQ-038 Reset mid-operation discards any in-flight vector; an engine result arriving after reset is ignored.
REQ-039 err_timeout_out clears only on reset.

Structure
REQ-040 Package bn_ctrl_pkg holds: the Q4.12 vector typedef (N_LANES x signed 16), the FSM state enum, and the N_LANES constant.
REQ-041 Sub-module rr_arbiter (N_REQ requests plus rr_ptr in, one-hot grant plus index out) is combinational and instantiated once.

Verification
REQ-042 Single request: req_valid_in=001, lane0=16'sd4096, engine replies 1 cycle later with lane0=16'sd777 -> eng_valid_out pulses once with sel=0; rsp_valid_out=001 with lane0=777; xfer_count_out=1.
REQ-043 All three requesters held valid for 6 transactions, rsp_ready_in tied high -> grant order 0,1,2,0,1,2; each vector takes 4 cycles; xfer_count_out=6.
REQ-044 Engine silent after ISSUE -> err_timeout_out=1 exactly TIMEOUT_CYC=8 cycles after entering WAIT; no rsp_valid_out; next request is served normally with err_timeout_out still 1.
REQ-045 rsp_ready_in[1] withheld for 10 cycles while eng_valid_in toggles -> rsp_data_out stable; rsp_valid_out=010 throughout; no new grant.
REQ-046 Reset asserted in WAIT, then engine valid arrives -> all outputs 0; the late result is ignored; the next grant goes to requester 0.
REQ-047 eng_valid_in stuck high from the start -> each result captured only in WAIT, one response per grant.
